mic_sample_scheduler: RTL and testbench
=======================================

Name: mic_sample_scheduler

Overview:
Paces the microphone ADC sampler at a fixed, programmable sample rate by issuing start_sample pulses and collecting each 10-bit result. Stores samples into a ping-pong frame buffer of FRAME_LEN entries and hands completed frames to a downstream consumer (FFT/visualiser) through a ready/ack handshake with random-access reads. Detects and counts sample-rate overruns and dropped frames.

Parameters:
DIV, 2500, clk cycles per sample period (2500 gives 40 kHz at 100 MHz); must be >= 2
FRAME_LEN, 256, samples per frame; power of two
ADDR_W, 8, log2(FRAME_LEN)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
enable  input  1  level; 1 = sampling runs
start_sample  output  1  one-cycle pulse to ADC sampler
sample_done  input  1  one-cycle pulse from sampler; sample valid this cycle
sample  input  10  ADC result
frame_ready  output  1  level; a complete frame is held for the reader
frame_ack  input  1  one-cycle pulse; reader releases held frame
rd_addr  input  ADDR_W  read index into held frame
rd_data  output  10  registered read data
frame_dropped  output  1  one-cycle pulse; completed frame discarded
overrun  output  1  one-cycle pulse; tick arrived during conversion
overrun_cnt  output  8  saturating overrun count

Behaviour:
- Reset (rst synchronous, active-high, clock clk): start_sample=0, frame_ready=0, frame_dropped=0, overrun=0, overrun_cnt=0, rd_data=0, tick counter=0, wr_idx=0, wr_bank=0, rd_bank=1, state=IDLE. Buffer contents not cleared.
- Tick counter: runs 0..DIV-1 while enable=1, wraps. Tick asserts in the cycle the counter equals DIV-1. Counter is held at 0 while enable=0.
- FSM states:
  - IDLE: entered from reset, or from CONVERT when the pending conversion completes with enable=0. Moves to WAIT_TICK when enable=1.
  - WAIT_TICK: on tick, drive start_sample=1 in the next cycle and go to CONVERT. If enable=0, go to IDLE.
  - CONVERT: waits for sample_done. On sample_done, store the sample, then go to WAIT_TICK if enable=1, else IDLE.
  - A tick while in CONVERT pulses overrun in the next cycle and increments overrun_cnt, saturating at 255. No extra start_sample is issued.
- sample_done outside CONVERT is ignored; nothing is stored.
- Deasserting enable mid-conversion: the conversion completes and is stored. The partial frame is kept, and re-enabling continues at wr_idx.
- Store: mem[wr_bank][wr_idx] <= sample, and wr_idx increments.
- Frame completion, when the write lands at wr_idx = FRAME_LEN-1:
  - Reader free (frame_ready=0, or frame_ack asserted the same cycle): next cycle frame_ready=1, rd_bank<=wr_bank, wr_bank toggles, wr_idx=0.
  - Reader still holding the frame: frame_dropped pulses next cycle, wr_idx=0, wr_bank unchanged (bank is overwritten). frame_ready and rd_bank are unchanged.
- frame_ack with frame_ready=1 and no simultaneous completion: frame_ready=0 next cycle.
- frame_ack with frame_ready=0: ignored.
- Ack in the same cycle as a completion: the new frame is delivered and frame_ready stays 1.
- Reads: rd_data <= mem[rd_bank][rd_addr], one-cycle latency, valid every cycle. With frame_ready=0 it returns the last delivered bank. The writer never writes rd_bank while frame_ready=1.
- Bench configuration: DIV=20, FRAME_LEN=4, ADDR_W=2. Sampler model returns sample_done 5 cycles after start_sample, with sample values 1, 2, 3, ...

Test Plan:
- Rate: enable=1 for 200 cycles -> start_sample pulses exactly 20 cycles apart, first pulse at cycle 20 after enable; overrun never asserts.
- Frame delivery: collect samples 1..4 -> frame_ready rises the cycle after 4th sample_done; rd_addr 0..3 gives rd_data 1,2,3,4 each one cycle later; frame_ack clears frame_ready next cycle.
- Ping-pong: hold frame 1 (no ack) while samples 5..8 arrive -> frame_dropped pulses once and rd_data still reads 1..4; after ack, samples 9..12 -> frame_ready, reads 9..12.
- Simultaneous ack and completion: frame_ack in the same cycle as the 4th store of the next frame -> frame_ready stays 1, reads return the new frame, no frame_dropped.
- Overrun: sampler delays sample_done 30 cycles -> overrun pulses once per missed tick, overrun_cnt increments, no second start_sample; after 300 overruns overrun_cnt=255.
- Enable/reset: drop enable 2 cycles after start_sample -> the sample is still stored and no further pulses occur. Assert rst mid-CONVERT -> all outputs return to reset values next cycle, and the late sample_done is ignored.

Source files
------------

// File: rtl/mic_sample_scheduler.sv
// Microphone sample scheduler: paces ADC conversions at a fixed rate and
// gathers results into a ping-pong frame buffer. Completed frames are handed
// to a random-access reader.
//
// Handshake (reader side): frame_ready is a level that means "a complete
// frame is held in rd_bank". The reader may read it at any rd_addr for as long
// as frame_ready=1. A one-cycle frame_ack pulse releases it, and frame_ready
// drops on the next cycle. An ack while frame_ready=0 is ignored. If a new
// frame completes while the reader still holds one, the new frame is discarded
// (frame_dropped) and the held frame is not disturbed. If a new frame completes
// in the same cycle as the ack, the new frame is delivered and frame_ready
// stays high.
module mic_sample_scheduler #(
  parameter int DIV       = 2500,
  parameter int FRAME_LEN = 256,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic              start_sample,
  input  logic              sample_done,
  input  logic [9:0]        sample,
  output logic              frame_ready,
  input  logic              frame_ack,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [9:0]        rd_data,
  output logic              frame_dropped,
  output logic              overrun,
  output logic [7:0]        overrun_cnt,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    CONVERT   = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]  tick_cnt;
  logic              tick;
  logic              start_d;
  logic              store;
  logic              ovr_d;

  logic [ADDR_W-1:0] wr_idx;
  logic              wr_bank;
  logic              rd_bank;
  logic              frame_last;
  logic              reader_free;

  // Two banks of FRAME_LEN samples, addressed as {bank, index}.
  logic [9:0] mem [0:2*FRAME_LEN-1];

  assign tick        = enable && (tick_cnt == CNT_MAX);
  assign frame_last  = store && (wr_idx == IDX_LAST);
  assign reader_free = !frame_ready || frame_ack;
  assign dbg_state   = state;

  // Sample-period counter: free-runs 0..DIV-1 while enabled, parked at 0 otherwise.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state plus the per-cycle strobes derived from it.
  always_comb begin
    state_next = state;
    start_d    = 1'b0;
    store      = 1'b0;
    ovr_d      = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_next = WAIT_TICK;
        end
      end
      WAIT_TICK: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (tick) begin
          start_d    = 1'b1;
          state_next = CONVERT;
        end
      end
      CONVERT: begin
        // A tick here means the sampler could not keep up with the rate.
        if (tick) begin
          ovr_d = 1'b1;
        end
        if (sample_done) begin
          store      = 1'b1;
          state_next = enable ? WAIT_TICK : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Registered sampler start pulse and overrun reporting.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_sample <= 1'b0;
      overrun      <= 1'b0;
      overrun_cnt  <= '0;
    end else begin
      start_sample <= start_d;
      overrun      <= ovr_d;
      if (ovr_d && (overrun_cnt != 8'hFF)) begin
        overrun_cnt <= overrun_cnt + 8'd1;
      end
    end
  end

  // Write pointer, bank swap and frame hand-off to the reader.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx        <= '0;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b1;
      frame_ready   <= 1'b0;
      frame_dropped <= 1'b0;
    end else begin
      frame_dropped <= 1'b0;
      if (store) begin
        wr_idx <= wr_idx + ADDR_W'(1);
      end
      if (frame_last) begin
        if (reader_free) begin
          frame_ready <= 1'b1;
          rd_bank     <= wr_bank;
          wr_bank     <= ~wr_bank;
        end else begin
          // Reader still busy: discard by refilling the same bank.
          frame_dropped <= 1'b1;
        end
      end else if (frame_ack) begin
        frame_ready <= 1'b0;
      end
    end
  end

  // Sample storage; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (store) begin
      mem[{wr_bank, wr_idx}] <= sample;
    end
  end

  // Registered random-access read from the delivered bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[{rd_bank, rd_addr}];
    end
  end

endmodule

// File: tb/tb_mic_sample_scheduler.sv
// Directed bench for mic_sample_scheduler with an abstract reference model
// (conversion-busy flag, enabled-cycle count, frame queues) checked every cycle.
module tb_mic_sample_scheduler;

  localparam int DIV  = 20;
  localparam int FLEN = 4;
  localparam int AW   = 2;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          start_sample;
  logic          sample_done = 1'b0;
  logic [9:0]    sample = '0;
  logic          frame_ready;
  logic          frame_ack;
  logic [AW-1:0] rd_addr;
  logic [9:0]    rd_data;
  logic          frame_dropped;
  logic          overrun;
  logic [7:0]    overrun_cnt;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  mic_sample_scheduler #(.DIV(DIV), .FRAME_LEN(FLEN), .ADDR_W(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .start_sample  (start_sample),
    .sample_done   (sample_done),
    .sample        (sample),
    .frame_ready   (frame_ready),
    .frame_ack     (frame_ack),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .frame_dropped (frame_dropped),
    .overrun       (overrun),
    .overrun_cnt   (overrun_cnt),
    .dbg_state     (dbg_state)
  );

  // ---------------- sampler model ----------------
  // Answers each start_sample with sample_done samp_delay cycles later,
  // returning 1, 2, 3, ... in order.
  int  samp_delay = 5;
  int  next_val   = 1;
  int  cd         = 0;
  bit  pend       = 1'b0;
  logic seen_start;

  always begin
    @(posedge clk);
    seen_start = start_sample;
    #1;
    sample_done = 1'b0;
    if (pend) begin
      if (cd == 1) begin
        sample_done = 1'b1;
        sample      = next_val[9:0];
        next_val    = next_val + 1;
        pend        = 1'b0;
      end else begin
        cd = cd - 1;
      end
    end
    if (seen_start === 1'b1) begin
      pend = 1'b1;
      cd   = samp_delay - 1;
    end
  end

  // ---------------- reference model ----------------
  // A conversion is either in flight or not; ticks come every DIV enabled
  // cycles; frames are filled as a queue and delivered or discarded whole.
  bit         model_on = 1'b0;
  int         en_cnt;
  bit         conv;
  bit         tick_m;
  logic [9:0] part[$];
  logic [9:0] held[FLEN];
  bit         delivered;
  bit         m_ready;
  logic       exp_start, exp_ready, exp_drop, exp_ovr;
  logic [7:0] exp_cnt;
  logic [9:0] exp_rd;
  bit         rd_chk;

  always @(posedge clk) begin
    if (rst) begin
      en_cnt = 0; conv = 0; part.delete(); delivered = 0; m_ready = 0;
      exp_start = 0; exp_ready = 0; exp_drop = 0; exp_ovr = 0; exp_cnt = 0;
      exp_rd = 0; rd_chk = 1; model_on = 1;
    end else if (model_on) begin
      tick_m = enable && ((en_cnt % DIV) == DIV - 1);
      en_cnt = enable ? en_cnt + 1 : 0;
      rd_chk = delivered;
      exp_rd = held[rd_addr];
      exp_start = tick_m && !conv;
      exp_ovr   = tick_m && conv;
      if (exp_ovr && exp_cnt != 8'd255) exp_cnt = exp_cnt + 8'd1;
      exp_drop = 0;
      if (conv && sample_done) begin
        conv = 0;
        part.push_back(sample);
      end
      if (part.size() == FLEN) begin
        if (!m_ready || frame_ack) begin
          for (int i = 0; i < FLEN; i++) held[i] = part[i];
          delivered = 1;
          m_ready   = 1;
        end else begin
          exp_drop = 1;
        end
        part.delete();
      end else if (frame_ack) begin
        m_ready = 0;
      end
      if (exp_start) conv = 1;
      exp_ready = m_ready;
    end
  end

  // ---------------- scoreboard / compare ----------------
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_drop = 0, n_start = 0, n_ovr = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // One cycle: advance to the negedge, check the model, tally output pulses.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (model_on) begin
      cmp("start_sample",  32'(start_sample),  32'(exp_start));
      cmp("frame_ready",   32'(frame_ready),   32'(exp_ready));
      cmp("frame_dropped", 32'(frame_dropped), 32'(exp_drop));
      cmp("overrun",       32'(overrun),       32'(exp_ovr));
      cmp("overrun_cnt",   32'(overrun_cnt),   32'(exp_cnt));
      if (rd_chk) cmp("rd_data", 32'(rd_data), 32'(exp_rd));
    end
    if (frame_dropped === 1'b1) n_drop++;
    if (start_sample === 1'b1) n_start++;
    if (overrun === 1'b1) n_ovr++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic read_frame(input int base);
    for (int a = 0; a < FLEN; a++) begin
      rd_addr = AW'(a);
      step();
      cmp("rd_literal", 32'(rd_data), 32'(base + a));
    end
  endtask

  task automatic wait_done(input int val);
    bit found = 0;
    for (int k = 0; k < 2000; k++) begin
      step();
      if (sample_done && int'(sample) == val) begin
        found = 1;
        break;
      end
    end
    cmp("wait_sample_done", 32'(found), 32'd1);
  endtask

  task automatic wait_start();
    bit found = 0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (start_sample === 1'b1) begin
        found = 1;
        break;
      end
    end
    cmp("wait_start", 32'(found), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  int first_s, second_s, done_k, ready_k, d0, o0, s0;

  initial begin
    rst = 1; enable = 0; frame_ack = 0; rd_addr = '0;
    step(); step();
    cmp("rst_start",   32'(start_sample),  32'd0);
    cmp("rst_ready",   32'(frame_ready),   32'd0);
    cmp("rst_drop",    32'(frame_dropped), 32'd0);
    cmp("rst_ovr",     32'(overrun),       32'd0);
    cmp("rst_ovr_cnt", 32'(overrun_cnt),   32'd0);
    cmp("rst_rd_data", 32'(rd_data),       32'd0);
    cmp("rst_state",   32'(dbg_state),     32'd0);
    rst = 0;

    // Rate and first frame: starts at 20, 40, ...; 4th done at 85; ready at 86.
    enable = 1;
    first_s = 0; second_s = 0; done_k = 0; ready_k = 0;
    for (int k = 1; k <= 120; k++) begin
      step();
      if (start_sample) begin
        if (first_s == 0) first_s = k;
        else if (second_s == 0) second_s = k;
      end
      if (sample_done) done_k = k;
      if (frame_ready) begin
        ready_k = k;
        break;
      end
    end
    cmp("first_start",  32'(first_s),  32'd20);
    cmp("second_start", 32'(second_s), 32'd40);
    cmp("fourth_done",  32'(done_k),   32'd85);
    cmp("ready_rise",   32'(ready_k),  32'd86);
    read_frame(1);

    // Held frame: samples 5..8 are dropped, reads still return 1..4.
    d0 = n_drop;
    wait_done(8);
    step();
    cmp("drop_once", 32'(n_drop - d0), 32'd1);
    read_frame(1);
    frame_ack = 1;
    step();
    frame_ack = 0;
    cmp("ack_clears", 32'(frame_ready), 32'd0);

    wait_done(12);
    step();
    cmp("ready_9_12", 32'(frame_ready), 32'd1);
    read_frame(9);

    // Ack in the same cycle as the completing store of 13..16.
    d0 = n_drop;
    wait_done(16);
    frame_ack = 1;
    step();
    frame_ack = 0;
    cmp("ack_and_complete_ready", 32'(frame_ready), 32'd1);
    step();
    cmp("ack_and_complete_nodrop", 32'(n_drop - d0), 32'd0);
    read_frame(13);
    cmp("no_overrun_at_rate", 32'(n_ovr), 32'd0);

    // Overrun: slow sampler misses one tick per conversion until saturation.
    samp_delay = 30;
    o0 = n_ovr;
    for (int k = 0; k < 15000; k++) begin
      step();
      if (n_ovr - o0 >= 300) break;
    end
    cmp("ovr_300_pulses", 32'(n_ovr - o0 >= 300), 32'd1);
    cmp("ovr_cnt_sat",    32'(overrun_cnt),       32'd255);

    // Enable dropped two cycles after a start: sample stored, no more starts.
    samp_delay = 5;
    wait_start();
    step(); step();
    enable = 0;
    s0 = n_start;
    repeat (60) step();
    cmp("no_start_disabled", 32'(n_start - s0), 32'd0);

    // Re-enable, continue the partial frame, then reset mid-conversion.
    enable = 1;
    for (int i = 0; i < 4; i++) wait_done(0 + next_val);
    wait_start();
    step(); step();
    rst = 1; enable = 0;
    step();
    rst = 0;
    cmp("mid_rst_start",   32'(start_sample),  32'd0);
    cmp("mid_rst_ready",   32'(frame_ready),   32'd0);
    cmp("mid_rst_ovr",     32'(overrun),       32'd0);
    cmp("mid_rst_ovr_cnt", 32'(overrun_cnt),   32'd0);
    cmp("mid_rst_rd_data", 32'(rd_data),       32'd0);
    s0 = n_start; d0 = n_drop;
    repeat (12) step();
    cmp("late_done_ignored_ready", 32'(frame_ready),    32'd0);
    cmp("late_done_no_start",      32'(n_start - s0),   32'd0);
    cmp("late_done_no_drop",       32'(n_drop - d0),    32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
